// File: rtl/display_sequencer_if.sv
// Event and view signals between keypad/ALU control and the display sequencer.
// master: event source and display consumer; slave: the sequencer itself.
interface display_sequencer_if;
    logic       key_pulse;
    logic       result_pulse;
    logic       clear_pulse;
    logic [1:0] display_select;
    logic       splash_active;
    logic       hold_active;

    modport master (
        output key_pulse, result_pulse, clear_pulse,
        input  display_select, splash_active, hold_active
    );

    modport slave (
        input  key_pulse, result_pulse, clear_pulse,
        output display_select, splash_active, hold_active
    );
endinterface

// File: rtl/display_sequencer.sv
// Display policy controller: splash, entry view, result view with minimum hold.
// Define DISPSEQ_IDLE_SPLASH_EN to return to splash after an idle timeout.
module display_sequencer #(
    parameter int unsigned     CNT_W              = 26,
    parameter longint unsigned SPLASH_CYCLES      = 50000000,
    parameter longint unsigned RESULT_HOLD_CYCLES = 25000000,
    parameter longint unsigned IDLE_CYCLES        = 64'd1500000000 % (64'd1 << CNT_W)
) (
    input  logic clk,
    input  logic reset,
    display_sequencer_if.slave dsp
);

`ifdef DISPSEQ_IDLE_SPLASH_EN
    localparam bit IDLE_EN = 1'b1;
`else
    localparam bit IDLE_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] SPLASH_LAST = CNT_W'(SPLASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESULT_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_CYCLES - 1);

    typedef enum logic [1:0] {SPLASH, ENTRY, RESULT} state_t;

    state_t           state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt, cnt_inc;
    logic             pending_key, nxt_pending;
    logic             hold_done, nxt_hold_done;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        nxt_state     = state;
        nxt_cnt       = cnt;
        nxt_pending   = pending_key;
        nxt_hold_done = hold_done;
        if (dsp.clear_pulse) begin
            nxt_state     = ENTRY;
            nxt_cnt       = '0;
            nxt_pending   = 1'b0;
            nxt_hold_done = 1'b0;
        end else begin
            unique case (state)
                SPLASH: begin
                    if (cnt == SPLASH_LAST) begin
                        nxt_state = ENTRY;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt_inc;
                    end
                end
                ENTRY: begin
                    if (dsp.result_pulse) begin
                        nxt_state     = RESULT;
                        nxt_cnt       = '0;
                        nxt_pending   = 1'b0;
                        nxt_hold_done = 1'b0;
                    end else if (dsp.key_pulse) begin
                        nxt_cnt = '0;
                    end else if (IDLE_EN) begin
                        if (cnt == IDLE_LAST) begin
                            nxt_state = SPLASH;
                            nxt_cnt   = '0;
                        end else begin
                            nxt_cnt = cnt_inc;
                        end
                    end
                end
                RESULT: begin
                    if (dsp.result_pulse) begin
                        nxt_cnt       = '0;
                        nxt_pending   = 1'b0;
                        nxt_hold_done = 1'b0;
                    end else if (!hold_done) begin
                        // A key seen during the hold is deferred until the hold expires.
                        if (cnt == HOLD_LAST) begin
                            nxt_cnt = '0;
                            if (pending_key || dsp.key_pulse) begin
                                nxt_state   = ENTRY;
                                nxt_pending = 1'b0;
                            end else begin
                                nxt_hold_done = 1'b1;
                            end
                        end else begin
                            nxt_cnt = cnt_inc;
                            if (dsp.key_pulse) nxt_pending = 1'b1;
                        end
                    end else if (dsp.key_pulse) begin
                        nxt_state     = ENTRY;
                        nxt_cnt       = '0;
                        nxt_hold_done = 1'b0;
                    end else if (IDLE_EN) begin
                        if (cnt == IDLE_LAST) begin
                            nxt_state     = SPLASH;
                            nxt_cnt       = '0;
                            nxt_hold_done = 1'b0;
                        end else begin
                            nxt_cnt = cnt_inc;
                        end
                    end
                end
                default: nxt_state = SPLASH;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the triggering edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= SPLASH;
            cnt                <= '0;
            pending_key        <= 1'b0;
            hold_done          <= 1'b0;
            dsp.display_select <= 2'b10;
            dsp.splash_active  <= 1'b1;
            dsp.hold_active    <= 1'b0;
        end else begin
            state             <= nxt_state;
            cnt               <= nxt_cnt;
            pending_key       <= nxt_pending;
            hold_done         <= nxt_hold_done;
            dsp.splash_active <= (nxt_state == SPLASH);
            dsp.hold_active   <= (nxt_state == RESULT) && !nxt_hold_done;
            unique case (nxt_state)
                SPLASH:  dsp.display_select <= 2'b10;
                ENTRY:   dsp.display_select <= 2'b00;
                RESULT:  dsp.display_select <= 2'b01;
                default: dsp.display_select <= 2'b10;
            endcase
        end
    end

endmodule
